// File: rtl/intdiv_radix.sv
// Radix-2^BITSPERCYCLE restoring integer divider with signed and W-type (32-bit) support.
// Latency: N/BITSPERCYCLE cycles in BUSY (N = 32 or XLEN). With IDIV_EARLYTERM_EN it is data dependent. Divide-by-zero skips BUSY.
// Backpressure: the result is held in DONE until out_ready. in_ready = IDLE | (DONE & out_ready), so requests can run back to back.
//
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   flush               synchronous abort; discards any operation or pending result
//   in_valid/in_ready   request handshake for srca (dividend), srcb (divisor), is_signed, w64
//   out_valid/out_ready result handshake for quot, rem (both forced to zero while out_valid is low)
//   busy                high whenever not IDLE
// Optional build macro: IDIV_EARLYTERM_EN skips leading-zero bits of |A| (same results, shorter latency).
module intdiv_radix #(
  parameter int XLEN         = 64,
  parameter int BITSPERCYCLE = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            is_signed,
  input  logic            w64,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem,
  output logic            busy
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, stateNext;

  // remReg carries one extra bit so the shifted partial remainder never overflows.
  // dvdReg shifts the dividend out of its top and the quotient bits in at its bottom.
  logic [XLEN:0]   remReg, remNext;
  logic [XLEN-1:0] dvdReg, dvdNext, dvsReg;
  logic            qNeg, rNeg, wReg;
  logic [CW-1:0]   cnt;

  logic            wType, negA, negB, divZero, accept;
  logic [XLEN-1:0] extA, extB, absA, absB, dvdInit;
  logic [CW-1:0]   steps;
  int              stepsInt;
`ifdef IDIV_EARLYTERM_EN
  int              sigBits;
`endif
  logic [XLEN-1:0] qSigned, rSigned;

  function automatic logic [XLEN-1:0] sextW(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = 32; i < XLEN; i++) r[i] = v[31];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zextW(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = 32; i < XLEN; i++) r[i] = 1'b0;
    return r;
  endfunction

  // Operand preparation: width selection, magnitudes, signs and step count.
  always_comb begin
    wType = (XLEN == 64) && w64;
    extA  = srca;
    extB  = srcb;
    if (wType) begin
      extA = is_signed ? sextW(srca) : zextW(srca);
      extB = is_signed ? sextW(srcb) : zextW(srcb);
    end
    negA    = is_signed & extA[XLEN-1];
    negB    = is_signed & extB[XLEN-1];
    absA    = negA ? -extA : extA;
    absB    = negB ? -extB : extB;
    divZero = (extB == '0);
`ifdef IDIV_EARLYTERM_EN
    sigBits = 0;
    for (int i = 0; i < XLEN; i++) begin
      if (absA[i]) sigBits = i + 1;
    end
    stepsInt = (sigBits + BITSPERCYCLE - 1) / BITSPERCYCLE;
    if (stepsInt == 0) stepsInt = 1;
`else
    stepsInt = (wType ? 32 : XLEN) / BITSPERCYCLE;
`endif
    steps = CW'(stepsInt);
    // Aligning the dividend so exactly steps*BITSPERCYCLE bits get consumed also
    // covers the W-type case: the low 32 bits of dvdReg end up holding the quotient.
    dvdInit = absA << (XLEN - stepsInt * BITSPERCYCLE);
  end

  // BITSPERCYCLE restoring steps chained in one cycle.
  always_comb begin
    remNext = remReg;
    dvdNext = dvdReg;
    for (int k = 0; k < BITSPERCYCLE; k++) begin
      remNext = {remNext[XLEN-1:0], dvdNext[XLEN-1]};
      dvdNext = {dvdNext[XLEN-2:0], 1'b0};
      if (remNext >= {1'b0, dvsReg}) begin
        remNext    = remNext - {1'b0, dvsReg};
        dvdNext[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    accept    = in_valid && in_ready && !flush;
    stateNext = state;
    if (flush)                                stateNext = IDLE;
    else if (accept)                          stateNext = divZero ? DONE : BUSY;
    else if (state == BUSY && cnt == CW'(1))  stateNext = DONE;
    else if (state == DONE && out_ready)      stateNext = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remReg <= '0;
      dvdReg <= '0;
      dvsReg <= '0;
      qNeg   <= 1'b0;
      rNeg   <= 1'b0;
      wReg   <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      dvsReg <= absB;
      wReg   <= wType;
      if (divZero) begin
        // Quotient of all ones and the raw dividend as remainder, never negated.
        dvdReg <= '1;
        remReg <= {1'b0, extA};
        qNeg   <= 1'b0;
        rNeg   <= 1'b0;
        cnt    <= '0;
      end else begin
        dvdReg <= dvdInit;
        remReg <= '0;
        qNeg   <= negA ^ negB;
        rNeg   <= negA;
        cnt    <= steps;
      end
    end else if (state == BUSY) begin
      remReg <= remNext;
      dvdReg <= dvdNext;
      cnt    <= cnt - CW'(1);
    end
  end

  // Most-negative / -1 needs no special case: the magnitude 2^(N-1) with a positive
  // quotient sign already reads back as the most-negative value.
  always_comb begin
    qSigned = qNeg ? -dvdReg : dvdReg;
    rSigned = rNeg ? -remReg[XLEN-1:0] : remReg[XLEN-1:0];
    if (wReg) begin
      qSigned = sextW(qSigned);
      rSigned = sextW(rSigned);
    end
    quot = '0;
    rem  = '0;
    if (state == DONE) begin
      quot = qSigned;
      rem  = rSigned;
    end
  end
endmodule

// File: tb/tb_intdiv_radix.sv
module tb_intdiv_radix;
  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, is_signed, w64;
  logic        out_valid, out_ready, busy;
  logic [63:0] srca, srcb, quot, rem;

  intdiv_radix #(.XLEN(64), .BITSPERCYCLE(2)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .srca(srca), .srcb(srcb), .is_signed(is_signed), .w64(w64),
    .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef IDIV_EARLYTERM_EN
  localparam int LAT_SMALL = 5;
`else
  localparam int LAT_SMALL = 33;
`endif

  typedef struct {
    int          id;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   nChecks = 0;
  int   nPass   = 0;
  int   cyc     = 0;
  int   opId    = 0;
  int   lastPop = -1;
  int   lastAcc = -2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%h, want 0x%h", tag, got, exp);
  endtask

  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                                input logic w, output logic [63:0] q, output logic [63:0] r);
    logic [31:0] a32, b32, q32, r32;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (sgn) begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a;
      end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 64'd0;
      end else if (sgn) begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end else begin
        q = a / b; r = a % b;
      end
    end
  endfunction

  // Drive a request until accepted; optionally record its expected result.
  task automatic doReq(input logic [63:0] a, input logic [63:0] b, input logic sgn, input logic w,
                       input logic [63:0] eq, input logic [63:0] er, input int lat, input bit keep);
    exp_t e;
    bit   ok;
    int   guard;
    srca = a; srcb = b; is_signed = sgn; w64 = w; in_valid = 1'b1;
    ok = 1'b0;
    guard = 0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = in_ready && !flush;
      guard++;
    end
    if (!ok) chk($sformatf("op%0d.acceptTimeout", opId), 64'd0, 64'd1);
    else if (keep) begin
      e.id = opId; e.q = eq; e.r = er; e.lat = lat; e.acc = cyc + 1;
      sb.push_back(e);
    end
    lastAcc = cyc + 1;
    opId++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Scoreboard: results are consumed on the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) chk("spuriousResult", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk($sformatf("op%0d.quot", e.id), quot, e.q);
        chk($sformatf("op%0d.rem", e.id), rem, e.r);
        if (e.lat >= 0) chk($sformatf("op%0d.latency", e.id), 64'(cyc + 1 - e.acc), 64'(e.lat));
        lastPop = cyc + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] a, b, eq, er;
    logic        sgn, w;
    bit          sawValid;
    int          guard;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    srca = '0; srcb = '0; is_signed = 1'b0; w64 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.busy", {63'd0, busy}, 64'd0);
    chk("rst.quot", quot, 64'd0);
    chk("rst.rem", rem, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Directed cases.
    doReq(64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, LAT_SMALL, 1'b1);
    doReq(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, -1, 1'b1);
    doReq(64'd5, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1, 1'b1);
    doReq(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
          64'h8000_0000_0000_0000, 64'd0, -1, 1'b1);
    doReq(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
          64'hFFFF_FFFF_8000_0000, 64'd0, 17, 1'b1);
    doReq(64'hDEAD_BEEF_1234_5678, 64'h0000_0000_0000_0000, 1'b1, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_1234_5678, 1, 1'b1);

    // Hold the result with out_ready low, then consume it and accept the next request on the same edge.
    guard = 0;
    while (busy && guard < 200) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    out_ready = 1'b0;
    doReq(64'd1000, 64'd7, 1'b0, 1'b0, 64'd142, 64'd6, -1, 1'b1);
    guard = 0;
    while (!out_valid && guard < 100) begin @(negedge clk); guard++; end
    chk("stall.valid", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d.quot", i), quot, 64'd142);
      chk($sformatf("stall%0d.rem", i), rem, 64'd6);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    doReq(64'd77, 64'd10, 1'b0, 1'b0, 64'd7, 64'd7, LAT_SMALL, 1'b1);
    chk("b2b.noBubble", 64'(lastAcc), 64'(lastPop));

    // Flush while BUSY: nothing may come out, then a fresh request works.
    guard = 0;
    while (busy && guard < 200) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    doReq(64'hFFFF_0000_1234_5678, 64'd3, 1'b0, 1'b0, 64'd0, 64'd0, -1, 1'b0);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush.busyBefore", {63'd0, busy}, 64'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush.idle", {63'd0, busy}, 64'd0);
    chk("flush.out_valid", {63'd0, out_valid}, 64'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    chk("flush.noResult", {63'd0, sawValid}, 64'd0);
    @(posedge clk); #1;
    doReq(64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0, -1, 1'b1);

    // Reset in the middle of an operation discards it.
    guard = 0;
    while (busy && guard < 200) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    doReq(64'hFFFF_0000_1234_5678, 64'd3, 1'b0, 1'b0, 64'd0, 64'd0, -1, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midRst.busy", {63'd0, busy}, 64'd0);
    chk("midRst.quot", quot, 64'd0);
    @(negedge clk) reset_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    chk("midRst.noResult", {63'd0, sawValid}, 64'd0);
    @(posedge clk); #1;

    // Random mix, issued back to back.
    for (int i = 0; i < 24; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case (i % 4)
        1: b = 64'($urandom_range(0, 9));
        2: b = b >> $urandom_range(0, 63);
        3: a = a >> $urandom_range(0, 63);
        default: ;
      endcase
      if (i % 7 == 5) b = b & 64'hFFFF_FFFF_0000_0000;
      sgn = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      model(a, b, sgn, w, eq, er);
      doReq(a, b, sgn, w, eq, er, -1, 1'b1);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 300) begin @(negedge clk); guard++; end
    chk("drain.pending", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/intdiv_radix.md
INTDIV_RADIX -- requirements
Module: intdiv_radix

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning operand/result width (legal: 32, 64).
REQ-002 SHALL have parameter BITSPERCYCLE, default 2, meaning quotient bits retired per cycle (legal: 1, 2, 4).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-006 SHALL have ports in_valid  input  1 and in_ready  output  1  request handshake.
REQ-007 SHALL have ports srca, srcb  input  XLEN  dividend and divisor.
REQ-008 SHALL have ports is_signed, w64  input  1 each  signed operation; W-type (32-bit) operation, honoured only when XLEN=64.
REQ-009 SHALL have ports out_valid  output  1 and out_ready  input  1  result handshake.
REQ-010 SHALL have ports quot, rem  output  XLEN  quotient and remainder.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE.
REQ-013 SHALL drive in_ready = (IDLE) | (DONE & out_ready), so a new request may be accepted in the same cycle a result is consumed.
REQ-014 SHALL accept a request on the edge with in_valid & in_ready, latching |srca|, |srcb|, the quotient sign (sign(A) XOR sign(B)) and the remainder sign (sign(A)).
REQ-015 SHALL use operand width N = 32 when w64=1 and XLEN=64, else N = XLEN; for W-type, srca[31:0] and srcb[31:0] are sign- or zero-extended per is_signed.
REQ-016 SHALL, on accept with a nonzero divisor, enter BUSY for S cycles, retiring BITSPERCYCLE restoring-division steps per cycle, then enter DONE.
REQ-017 SHALL, on accept with a zero divisor, go directly to DONE with quot = all ones and rem = srca (W-type: sign-extended srca[31:0]).
REQ-018 SHALL assert out_valid only in DONE and hold quot/rem stable until out_valid & out_ready.
REQ-019 SHALL negate the quotient or remainder in DONE per the latched signs; signed overflow (most-negative / -1) SHALL yield quot = most-negative, rem = 0.
REQ-020 SHALL sign-extend bit 31 of both W-type results to XLEN.
REQ-021 SHALL leave DONE on out_ready to IDLE, or to BUSY/DONE if a new request is accepted in the same cycle.
REQ-022 SHALL, on flush, go to IDLE on the next edge and deassert out_valid, discarding any result; flush has priority over accept.
REQ-023 SHALL keep quot and rem at zero whenever out_valid is low.

Reset
REQ-024 SHALL, while reset_n is low, asynchronously force IDLE, out_valid=0, busy=0, quot=0, rem=0, with in_ready=1 once released.
REQ-025 SHALL, on reset asserted mid-operation, discard the operation without producing a result.

Configuration
REQ-026 SHALL recognise the macro IDIV_EARLYTERM_EN.
REQ-027 SHALL, without IDIV_EARLYTERM_EN, use S = N/BITSPERCYCLE (fixed latency).
REQ-028 SHALL, with IDIV_EARLYTERM_EN, count leading zeros LZ of |A| within N bits, use S = max(1, ceil((N-LZ)/BITSPERCYCLE)), and pre-shift the dividend left by N - S*BITSPERCYCLE bits on accept; results SHALL be identical to the fixed-latency build.

Verification
(XLEN=64, BITSPERCYCLE=2; accept edge = cycle t; out_ready=1 unless stated.)
REQ-029 SHALL cover unsigned 100/7 -> quot=14, rem=2; out_valid at t+33 without the macro, at t+5 with it.
REQ-030 SHALL cover signed -7/2 -> quot=0xFFFFFFFFFFFFFFFD, rem=0xFFFFFFFFFFFFFFFF.
REQ-031 SHALL cover 5/0 -> quot=0xFFFFFFFFFFFFFFFF, rem=5, out_valid at t+1.
REQ-032 SHALL cover signed 0x8000000000000000 / -1 -> quot=0x8000000000000000, rem=0; then W-type signed 0x80000000 / -1 -> quot=0xFFFFFFFF80000000, rem=0, out_valid at t+17 without the macro.
REQ-033 SHALL cover out_ready held low 10 cycles in DONE -> results stable; on release, a back-to-back request accepted the same cycle -> its correct result, no bubble.
REQ-034 SHALL cover flush at t+5 of a BUSY operation -> IDLE at t+6, no out_valid; the next request 9/3 -> quot=3, rem=0.
